delay_tap_monitor: RTL and testbench

Parametrised on-chip delay-chain timing monitor. It launches alternating transitions into a chain of `TAPS` segments of `2*P` kept `cinv` inverters and captures the selected tap one clock later. It counts launch/capture mismatches over a programmed number of trials. It sits beside the existing single-chain test structures and is driven by the design's control registers via a start/done handshake.

---
 rtl/delay_mon_pkg.sv | 20 ++
 rtl/cinv.sv | 9 +
 rtl/delay_segment.sv | 26 ++
 rtl/delay_tap_monitor.sv | 136 +++++++++++++
 tb/tb_delay_tap_monitor.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/delay_mon_pkg.sv
// Shared types for the delay-chain timing monitor: FSM state encoding and
// the tap-select width helper.
package delay_mon_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_LAUNCH  = 3'd1,
        S_CAPTURE = 3'd2,
        S_COMPARE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    // A single-tap build still needs a 1-bit select port.
    function automatic int sel_width(input int taps);
        return (taps > 1) ? $clog2(taps) : 1;
    endfunction

endpackage

// File: rtl/cinv.sv
// Behavioural model of the cinv library inverter cell (zero delay).
module cinv (
    input  logic a,
    output logic y
);

    assign y = ~a;

endmodule

// File: rtl/delay_segment.sv
// One delay segment: 2*P cascaded cinv cells, so the segment is non-inverting.
module delay_segment #(
    parameter int P = 2
) (
    input  logic a,
    output logic y
);

    // Each stage owns its own nets so the chain is not seen as a self-loop.
    for (genvar i = 0; i < 2 * P; i++) begin : g_inv
        logic inv_in;
        logic inv_out;
        if (i == 0) begin : g_head
            assign inv_in = a;
        end else begin : g_tail
            assign inv_in = g_inv[i-1].inv_out;
        end
        (* keep *) cinv u_inv (
            .a (inv_in),
            .y (inv_out)
        );
    end

    assign y = g_inv[2*P-1].inv_out;

endmodule

// File: rtl/delay_tap_monitor.sv
// Delay-chain timing monitor: launch/capture trials through TAPS segments with a
// start/done handshake. Optional self-check bypass path under DELAY_MON_BYPASS_EN.
module delay_tap_monitor
    import delay_mon_pkg::*;
#(
    parameter  int P     = 2,
    parameter  int TAPS  = 4,
    parameter  int CNT_W = 8,
    localparam int SEL_W = sel_width(TAPS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SEL_W-1:0] tap_sel,
    input  logic [CNT_W-1:0] trials,
`ifdef DELAY_MON_BYPASS_EN
    input  logic             bypass,
`endif
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [SEL_W-1:0] TAP_MAX = SEL_W'(TAPS - 1);

    state_e           state;
    logic [SEL_W-1:0] tap_q;
    logic [CNT_W-1:0] trials_q;
    logic [CNT_W-1:0] trial_cnt;
    logic [CNT_W-1:0] trial_nxt;
    logic             launch_q;
    logic             capture_q;
    logic             expect_q;
    logic [TAPS-1:0]  taps;
    (* keep *) logic  tap_out;
    logic             capture_d;
`ifdef DELAY_MON_BYPASS_EN
    logic             bypass_q;
`endif

    // Segment k is driven by segment k-1; tap k is the output of segment k.
    for (genvar k = 0; k < TAPS; k++) begin : g_seg
        logic seg_in;
        logic seg_out;
        if (k == 0) begin : g_first
            assign seg_in = launch_q;
        end else begin : g_next
            assign seg_in = g_seg[k-1].seg_out;
        end
        (* keep *) delay_segment #(.P(P)) u_seg (
            .a (seg_in),
            .y (seg_out)
        );
        assign taps[k] = seg_out;
    end

    // NOTE: every combinational output gets a default first, so no latch is inferred.
    always_comb begin
        tap_out   = taps[tap_q];
        capture_d = tap_out;
`ifdef DELAY_MON_BYPASS_EN
        if (bypass_q) capture_d = launch_q;
`endif
    end

    assign trial_nxt = trial_cnt + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments and an async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_count <= '0;
            launch_q  <= 1'b0;
            capture_q <= 1'b0;
            expect_q  <= 1'b0;
            tap_q     <= '0;
            trials_q  <= '0;
            trial_cnt <= '0;
`ifdef DELAY_MON_BYPASS_EN
            bypass_q  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        tap_q     <= (tap_sel > TAP_MAX) ? TAP_MAX : tap_sel;
                        trials_q  <= trials;
                        err_count <= '0;
                        trial_cnt <= '0;
                        busy      <= 1'b1;
`ifdef DELAY_MON_BYPASS_EN
                        bypass_q  <= bypass;
`endif
                        state     <= (trials == '0) ? S_DONE : S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    launch_q <= ~launch_q;
                    expect_q <= ~launch_q;
                    state    <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    capture_q <= capture_d;
                    state     <= S_COMPARE;
                end
                S_COMPARE: begin
                    if ((capture_q != expect_q) && (err_count != '1))
                        err_count <= err_count + CNT_W'(1);
                    trial_cnt <= trial_nxt;
                    if (trial_nxt == trials_q) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        state <= S_LAUNCH;
                    end
                end
                S_DONE: begin
                    // Entered without done set only on a zero-trial run: pulse one cycle later.
                    if (done) begin
                        done  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_tap_monitor.sv
// Scoreboard bench for delay_tap_monitor: a TAPS=5/CNT_W=8 unit and a
// TAPS=4/CNT_W=4 unit for counter saturation. Bypass test under DELAY_MON_BYPASS_EN.
module tb_delay_tap_monitor;
    import delay_mon_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] tap_sel;
    logic [7:0] trials;
    logic       busy;
    logic       done;
    logic [7:0] err_count;

    logic       start4;
    logic [1:0] tap_sel4;
    logic [3:0] trials4;
    logic       busy4;
    logic       done4;
    logic [3:0] err_count4;
`ifdef DELAY_MON_BYPASS_EN
    logic       bypass;
    logic       bypass4;
`endif

    int          checks = 0;
    int          errors = 0;
    int unsigned exp_q[$];

    // Late-arrival model: segments 2.. still show the previous launch value.
    logic [4:0] late_taps;
    logic [3:0] late_taps4;
    always_comb late_taps  = {{3{~dut.launch_q}}, {2{dut.launch_q}}};
    always_comb late_taps4 = {4{~dut4.launch_q}};

    always #5 clk = ~clk;

    delay_tap_monitor #(.P(2), .TAPS(5), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .tap_sel   (tap_sel),
        .trials    (trials),
`ifdef DELAY_MON_BYPASS_EN
        .bypass    (bypass),
`endif
        .busy      (busy),
        .done      (done),
        .err_count (err_count)
    );

    delay_tap_monitor #(.P(1), .TAPS(4), .CNT_W(4)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start4),
        .tap_sel   (tap_sel4),
        .trials    (trials4),
`ifdef DELAY_MON_BYPASS_EN
        .bypass    (bypass4),
`endif
        .busy      (busy4),
        .done      (done4),
        .err_count (err_count4)
    );

    task automatic run(input logic [2:0] ts, input logic [7:0] tr,
                       input int unsigned exp_err, input bit poke);
        int          n;
        int          lat;
        int          extra;
        bit          busy_ok;
        int unsigned exp_v;
        lat = (tr == 8'd0) ? 1 : 3 * int'(tr);
        exp_q.push_back(exp_err);
        @(negedge clk);
        start = 1'b1; tap_sel = ts; trials = tr;
        @(negedge clk);
        start = 1'b0;
        n = 0; busy_ok = 1'b1;
        while (done !== 1'b1 && n < lat + 10) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (poke && n == 2) begin start = 1'b1; tap_sel = 3'd4; trials = 8'd2; end
            if (poke && n == 3) start = 1'b0;
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL latency tap=%0d trials=%0d: got %0d cycles, want %0d", ts, tr, n, lat);
        end
        checks++;
        if (!busy_ok) begin
            errors++;
            $display("FAIL busy_during_run tap=%0d trials=%0d: busy dropped, want 1", ts, tr);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: got %b, want 0", busy);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (err_count !== 8'(exp_v)) begin
            errors++;
            $display("FAIL err_count tap=%0d trials=%0d: got %0d, want %0d", ts, tr, err_count, exp_v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || err_count !== 8'(exp_v)) begin
            errors++;
            $display("FAIL done_pulse_hold: done=%b err=%0d, want done=0 err=%0d", done, err_count, exp_v);
        end
        if (poke) begin
            extra = 0;
            repeat (10) begin
                @(negedge clk);
                if (done === 1'b1) extra++;
            end
            checks++;
            if (extra != 0) begin
                errors++;
                $display("FAIL single_done: got %0d extra done pulses, want 0", extra);
            end
        end
    endtask

    task automatic run4(input logic [3:0] tr, input int unsigned exp_err, input bit preload);
        int          n;
        int          lat;
        int unsigned exp_v;
        lat = 3 * int'(tr);
        exp_q.push_back(exp_err);
        @(negedge clk);
        start4 = 1'b1; tap_sel4 = 2'd3; trials4 = tr;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < lat + 10) begin
            if (preload && n == 4) begin
                force dut4.err_count = 4'hE;
                #1 release dut4.err_count;
            end
            @(negedge clk);
            n++;
        end
        checks++;
        if (n !== lat) begin
            errors++;
            $display("FAIL latency4 trials=%0d: got %0d cycles, want %0d", tr, n, lat);
        end
        exp_v = exp_q.pop_front();
        checks++;
        if (err_count4 !== 4'(exp_v)) begin
            errors++;
            $display("FAIL err_count4 trials=%0d preload=%0d: got %0d, want %0d", tr, preload, err_count4, exp_v);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 8'd0) begin
            errors++;
            $display("FAIL reset_in: busy=%b done=%b err=%0d, want 0 0 0", busy, done, err_count);
        end
        checks++;
        if (dut.launch_q !== 1'b0 || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL reset_state: launch=%b state=%0d, want 0 IDLE", dut.launch_q, dut.state);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count4 !== 4'd0) begin
            errors++;
            $display("FAIL reset_out: busy=%b done=%b err4=%0d, want 0 0 0", busy, done, err_count4);
        end
    endtask

    task automatic test_zero_delay();
        run(3'd0, 8'd8, 0, 1'b0);
        run(3'd4, 8'd5, 0, 1'b0);
    endtask

    task automatic test_slow_tap();
        force dut.taps = late_taps;
        run(3'd3, 8'd10, 10, 1'b0);
        run(3'd0, 8'd10, 0, 1'b0);
        run(3'd2, 8'd1, 1, 1'b0);
        run(3'd1, 8'd3, 0, 1'b0);
        run(3'd7, 8'd6, 6, 1'b0);
        release dut.taps;
    endtask

    task automatic test_trials_zero();
        force dut.taps = late_taps;
        run(3'd4, 8'd4, 4, 1'b0);
        run(3'd4, 8'd0, 0, 1'b0);
        release dut.taps;
    endtask

    task automatic test_start_while_busy();
        force dut.taps = late_taps;
        run(3'd3, 8'd3, 3, 1'b1);
        release dut.taps;
    endtask

    task automatic test_reset_mid_run();
        int n;
        force dut.taps = late_taps;
        @(negedge clk);
        start = 1'b1; tap_sel = 3'd3; trials = 8'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        checks++;
        if (err_count !== 8'd2 || dut.state !== S_CAPTURE) begin
            errors++;
            $display("FAIL pre_reset: err=%0d state=%0d, want 2 CAPTURE", err_count, dut.state);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_count !== 8'd0 || dut.state !== S_IDLE) begin
            errors++;
            $display("FAIL async_reset: busy=%b done=%b err=%0d state=%0d, want 0 0 0 IDLE",
                     busy, done, err_count, dut.state);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL no_done_after_reset: got %0d active cycles, want 0", n);
        end
        run(3'd3, 8'd2, 2, 1'b0);
        release dut.taps;
    endtask

    task automatic test_saturation();
        force dut4.taps = late_taps4;
        run4(4'd15, 15, 1'b0);
        run4(4'd15, 15, 1'b0);
        run4(4'd5, 15, 1'b1);
        release dut4.taps;
    endtask

`ifdef DELAY_MON_BYPASS_EN
    task automatic test_bypass();
        force dut.taps = late_taps;
        bypass = 1'b1;
        run(3'd4, 8'd6, 0, 1'b0);
        bypass = 1'b0;
        run(3'd4, 8'd2, 2, 1'b0);
        release dut.taps;
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0; tap_sel = '0; trials = '0;
        start4 = 1'b0; tap_sel4 = '0; trials4 = '0;
`ifdef DELAY_MON_BYPASS_EN
        bypass = 1'b0; bypass4 = 1'b0;
`endif
        test_reset();
        test_zero_delay();
        test_slow_tap();
        test_trials_zero();
        test_start_while_busy();
        test_reset_mid_run();
        test_saturation();
`ifdef DELAY_MON_BYPASS_EN
        test_bypass();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
